mybus_counter: RTL and testbench



---
 rtl/mybus_pkg.sv | 11 +
 rtl/mybus_if.sv | 28 ++
 rtl/mybus_counter_core.sv | 43 ++++
 rtl/mybus_counter.sv | 27 ++
 tb/tb_mybus_counter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mybus_pkg.sv
// mybus_pkg
//   Shared definitions for the myBus environment: the default data-lane
//   width and the matching data type. The myBus interface and the
//   mybus_counter blocks both import this package.
package mybus_pkg;

  localparam int MYBUS_D_WIDTH = 8;

  typedef logic [MYBUS_D_WIDTH-1:0] mybus_data_t;

endpackage : mybus_pkg

// File: rtl/mybus_if.sv
// myBus
//   Bus bundle between the testbench and the counter.
//   Ports:
//     clk     - bus clock, shared by both sides
//   Lanes:
//     enable  - count enable, written by the testbench side
//     data    - counter value, written by the DUT side
//   Modports:
//     DUT     - clk/enable in, data out
//     TB      - clk/data in, enable out
//   The data lane carries no valid/ready pair: it holds a registered value
//   that is meaningful on every cycle after reset, and the receiving side
//   samples it whenever it likes.
interface myBus
  import mybus_pkg::*;
#(
  parameter int D_WIDTH = MYBUS_D_WIDTH
) (
  input logic clk
);

  logic               enable;
  logic [D_WIDTH-1:0] data;

  modport DUT (input clk, input enable, output data);
  modport TB  (input clk, input data, output enable);

endinterface : myBus

// File: rtl/mybus_counter_core.sv
// mybus_counter_core
//   D_WIDTH-bit up-counter. Increments on every enabled edge, wraps modulo
//   2^D_WIDTH with no carry flag, and clears (rather than holds) on any
//   edge where enable is low.
//   Ports:
//     clk     in   rising-edge clock
//     rst     in   synchronous active-high reset (takes priority over enable)
//     enable  in   count enable
//     data    out  registered counter value
module mybus_counter_core
  import mybus_pkg::*;
#(
  parameter int D_WIDTH = MYBUS_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic [D_WIDTH-1:0] data
);

  logic [D_WIDTH-1:0] r_data;
  logic [D_WIDTH-1:0] w_data_next;

  // Dropping enable is a clear, not a pause; the add truncates to
  // D_WIDTH so the all-ones value rolls straight over to zero.
  always_comb begin
    w_data_next = '0;
    if (enable) begin
      w_data_next = r_data + D_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_data_next;
    end
  end

  assign data = r_data;

endmodule : mybus_counter_core

// File: rtl/mybus_counter.sv
// mybus_counter
//   Bus-side data source for the myBus environment. Thin wrapper that maps
//   the myBus.DUT modport lanes onto mybus_counter_core. The reset is a
//   separate port because the bus bundle carries no reset.
//   Ports:
//     bus     myBus.DUT  clk in, enable in, data out
//     rst     in         synchronous active-high reset
//   D_WIDTH must match the D_WIDTH of the connected myBus instance.
module mybus_counter
  import mybus_pkg::*;
#(
  parameter int D_WIDTH = MYBUS_D_WIDTH
) (
  myBus.DUT   bus,
  input logic rst
);

  mybus_counter_core #(
    .D_WIDTH (D_WIDTH)
  ) u_core (
    .clk    (bus.clk),
    .rst    (rst),
    .enable (bus.enable),
    .data   (bus.data)
  );

endmodule : mybus_counter

// File: tb/tb_mybus_counter.sv
// tb_mybus_counter
//   Bench for mybus_counter at D_WIDTH=8 and D_WIDTH=3. Driver tasks set
//   the inputs at the falling edge and push the hand-computed value expected
//   after the next rising edge; per-width monitors pop and compare shortly
//   after each rising edge.
module tb_mybus_counter;

  logic clk;
  logic rst8;
  logic rst3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp8_q[$];
  logic [2:0] exp3_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  myBus #(.D_WIDTH(8)) bus8 (.clk(clk));
  myBus #(.D_WIDTH(3)) bus3 (.clk(clk));

  mybus_counter #(.D_WIDTH(8)) dut8 (
    .bus (bus8),
    .rst (rst8)
  );

  mybus_counter #(.D_WIDTH(3)) dut3 (
    .bus (bus3),
    .rst (rst3)
  );

  // ---------------- driver tasks ----------------
  task automatic step8(input logic r, input logic en, input logic [7:0] exp);
    @(negedge clk);
    rst8        = r;
    bus8.enable = en;
    exp8_q.push_back(exp);
  endtask

  // Enable held high at both edges but pulsed low in between; the counter
  // must ignore the pulse.
  task automatic step8_glitch(input logic [7:0] exp);
    @(negedge clk);
    rst8        = 1'b0;
    bus8.enable = 1'b1;
    exp8_q.push_back(exp);
    #1 bus8.enable = 1'b0;
    #2 bus8.enable = 1'b1;
  endtask

  task automatic step3(input logic r, input logic en, input logic [2:0] exp);
    @(negedge clk);
    rst3        = r;
    bus3.enable = en;
    exp3_q.push_back(exp);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(posedge clk) begin
    #1;
    if (exp8_q.size() > 0) begin
      logic [7:0] e;
      e = exp8_q.pop_front();
      checks++;
      if (bus8.data !== e) begin
        errors++;
        $display("FAIL data8 at %0t: got %0d expected %0d", $time, bus8.data, e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp3_q.size() > 0) begin
      logic [2:0] e;
      e = exp3_q.pop_front();
      checks++;
      if (bus3.data !== e) begin
        errors++;
        $display("FAIL data3 at %0t: got %0d expected %0d", $time, bus3.data, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst8        = 1'b1;
    rst3        = 1'b1;
    bus8.enable = 1'b1;
    bus3.enable = 1'b0;

    // Reset held two edges with enable high, then released.
    step8(1'b1, 1'b1, 8'd0);
    step8(1'b1, 1'b1, 8'd0);
    step8(1'b0, 1'b1, 8'd1);

    // Count 1..5 from zero.
    step8(1'b0, 1'b0, 8'd0);
    step8(1'b0, 1'b1, 8'd1);
    step8(1'b0, 1'b1, 8'd2);
    step8(1'b0, 1'b1, 8'd3);
    step8(1'b0, 1'b1, 8'd4);
    step8(1'b0, 1'b1, 8'd5);

    // Clear: reach 3, drop enable one edge, resume 1, 2.
    step8(1'b0, 1'b0, 8'd0);
    step8(1'b0, 1'b1, 8'd1);
    step8(1'b0, 1'b1, 8'd2);
    step8(1'b0, 1'b1, 8'd3);
    step8(1'b0, 1'b0, 8'd0);
    step8(1'b0, 1'b1, 8'd1);
    step8(1'b0, 1'b1, 8'd2);

    // Glitch on enable between edges has no effect.
    step8_glitch(8'd3);
    step8_glitch(8'd4);

    // Wrap: 256 enabled edges from zero land on 0, the 257th on 1.
    step8(1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 256; i++) begin
      step8(1'b0, 1'b1, (i == 256) ? 8'd0 : 8'(i));
    end
    step8(1'b0, 1'b1, 8'd1);

    // Priority: at 7, rst and enable together clear; then count resumes.
    step8(1'b0, 1'b0, 8'd0);
    step8(1'b0, 1'b1, 8'd1);
    step8(1'b0, 1'b1, 8'd2);
    step8(1'b0, 1'b1, 8'd3);
    step8(1'b0, 1'b1, 8'd4);
    step8(1'b0, 1'b1, 8'd5);
    step8(1'b0, 1'b1, 8'd6);
    step8(1'b0, 1'b1, 8'd7);
    step8(1'b1, 1'b1, 8'd0);
    step8(1'b0, 1'b1, 8'd1);

    // Reset mid-count loses the count.
    step8(1'b0, 1'b1, 8'd2);
    step8(1'b1, 1'b0, 8'd0);
    step8(1'b0, 1'b1, 8'd1);

    // Width 3: nine enabled edges give 1..7, 0, 1.
    step3(1'b1, 1'b0, 3'd0);
    step3(1'b0, 1'b0, 3'd0);
    step3(1'b0, 1'b1, 3'd1);
    step3(1'b0, 1'b1, 3'd2);
    step3(1'b0, 1'b1, 3'd3);
    step3(1'b0, 1'b1, 3'd4);
    step3(1'b0, 1'b1, 3'd5);
    step3(1'b0, 1'b1, 3'd6);
    step3(1'b0, 1'b1, 3'd7);
    step3(1'b0, 1'b1, 3'd0);
    step3(1'b0, 1'b1, 3'd1);

    // Drain both scoreboards within a bounded number of cycles.
    for (int i = 0; i < 10; i++) begin
      if (exp8_q.size() == 0 && exp3_q.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (exp8_q.size() != 0 || exp3_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d/%0d expected 0/0", exp8_q.size(), exp3_q.size());
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mybus_counter
